// File: rtl/mem_stage_if.sv
// Bundles the EX->MEM, MEM->WB, data-SRAM response and ID-bypass signals of the MEM stage.
// The stage itself connects through the slave modport; its environment uses master.
interface mem_stage_if #(
   parameter int ES_TO_MS_BUS_WD = 75,
   parameter int MS_TO_WS_BUS_WD = 70
);
   logic                       ms_allowin;
   logic                       es_to_ms_valid;
   logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
   logic                       ws_allowin;
   logic                       ms_to_ws_valid;
   logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
   logic                       data_sram_data_ok;
   logic [31:0]                data_sram_rdata;
   logic [38:0]                ms_fwd_bus;

   modport master (
      output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
      input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
   );

   modport slave (
      input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
      output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
   );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: waits for the data-SRAM response, buffers it while WB stalls,
// extracts load data and forwards the result to WB and to the ID bypass network.
module mem_stage #(
   parameter int ES_TO_MS_BUS_WD = 75,
   parameter int MS_TO_WS_BUS_WD = 70
) (
   input  logic        clk,
   input  logic        resetn,
   mem_stage_if.slave  ms_if
);
   logic                       r_ms_valid;
   logic [ES_TO_MS_BUS_WD-1:0] r_es_bus;
   logic                       r_resp_buf_valid;
   logic [31:0]                r_resp_buf;

   logic [2:0]  w_ld_type;
   logic        w_mem_req;
   logic        w_res_from_mem;
   logic        w_gr_we;
   logic [4:0]  w_dest;
   logic [31:0] w_alu_result;
   logic [31:0] w_pc;

   logic        w_resp_got;
   logic        w_ready_go;
   logic        w_allowin;
   logic        w_accept;
   logic        w_capture;
   logic        w_load_block;
   logic [31:0] w_mem_rdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   logic [31:0] w_final_result;

   assign {w_ld_type, w_mem_req, w_res_from_mem, w_gr_we, w_dest, w_alu_result, w_pc} = r_es_bus;

   assign w_resp_got   = ms_if.data_sram_data_ok || r_resp_buf_valid;
   assign w_ready_go   = !w_mem_req || w_resp_got;
   assign w_allowin    = !r_ms_valid || (w_ready_go && ms_if.ws_allowin);
   assign w_accept     = ms_if.es_to_ms_valid && w_allowin;
   // Only a stalled memory op that has no response yet keeps the pulse; anything else drops it.
   assign w_capture    = ms_if.data_sram_data_ok && r_ms_valid && w_mem_req
                         && !r_resp_buf_valid && !ms_if.ws_allowin;
   assign w_load_block = r_ms_valid && w_res_from_mem && !w_resp_got;
   assign w_mem_rdata  = r_resp_buf_valid ? r_resp_buf : ms_if.data_sram_rdata;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_ms_valid       <= 1'b0;
         r_resp_buf_valid <= 1'b0;
      end else begin
         if (w_allowin) begin
            r_ms_valid <= ms_if.es_to_ms_valid;
         end
         if (w_accept) begin
            r_resp_buf_valid <= 1'b0;
         end else if (w_capture) begin
            r_resp_buf_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_es_bus <= ms_if.es_to_ms_bus;
      end
      if (w_capture) begin
         r_resp_buf <= ms_if.data_sram_rdata;
      end
   end

   always_comb begin
      w_byte = w_mem_rdata[7:0];
      case (w_alu_result[1:0])
         2'b01:   w_byte = w_mem_rdata[15:8];
         2'b10:   w_byte = w_mem_rdata[23:16];
         2'b11:   w_byte = w_mem_rdata[31:24];
         default: w_byte = w_mem_rdata[7:0];
      endcase
      w_half = w_alu_result[1] ? w_mem_rdata[31:16] : w_mem_rdata[15:0];
   end

   always_comb begin
      w_load_data = w_mem_rdata;
      case (w_ld_type)
         3'b001:  w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b010:  w_load_data = {24'b0, w_byte};
         3'b011:  w_load_data = {{16{w_half[15]}}, w_half};
         3'b100:  w_load_data = {16'b0, w_half};
         default: w_load_data = w_mem_rdata;
      endcase
   end

   assign w_final_result = w_res_from_mem ? w_load_data : w_alu_result;

   assign ms_if.ms_allowin     = w_allowin;
   assign ms_if.ms_to_ws_valid = r_ms_valid && w_ready_go;
   assign ms_if.ms_to_ws_bus   = {w_gr_we, w_dest, w_final_result, w_pc};
   assign ms_if.ms_fwd_bus     = {r_ms_valid && w_gr_we, w_dest, w_final_result, w_load_block};
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, multi-cycle corner sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_mem_stage;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   mem_stage_if #(.ES_TO_MS_BUS_WD(75), .MS_TO_WS_BUS_WD(70)) u_if ();

   mem_stage #(.ES_TO_MS_BUS_WD(75), .MS_TO_WS_BUS_WD(70)) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .ms_if  (u_if)
   );

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   typedef struct {
      string       name;
      logic [2:0]  ld;
      logic        mreq;
      logic        rfm;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [2:0]  ld;
      logic        mreq;
      logic        rfm;
      logic        gwe;
      logic [4:0]  dest;
      logic [31:0] alu;
      logic [31:0] pc;
   } ins_t;

   vec_t vecs[13];

   function automatic logic [74:0] pack(ins_t i);
      return {i.ld, i.mreq, i.rfm, i.gwe, i.dest, i.alu, i.pc};
   endfunction

   function automatic ins_t mk(logic [2:0] ld, logic mreq, logic rfm, logic [31:0] alu, logic [31:0] pc);
      ins_t i;
      i.ld = ld; i.mreq = mreq; i.rfm = rfm; i.gwe = 1'b1; i.dest = 5'd5; i.alu = alu; i.pc = pc;
      return i;
   endfunction

   // Load extraction written with shifts/modulo arithmetic rather than bit slicing.
   function automatic logic [31:0] extract(logic [2:0] ld, logic [1:0] a, logic [31:0] d);
      int unsigned b, h;
      b = (d >> (8 * a)) % 256;
      h = (d >> (16 * (a / 2))) % 65536;
      case (ld)
         3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd2:    return b;
         3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return h;
         default: return d;
      endcase
   endfunction

   task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic esv, input logic [74:0] bus, input logic wsa,
                        input logic dok, input logic [31:0] rdata);
      u_if.es_to_ms_valid    = esv;
      u_if.es_to_ms_bus      = bus;
      u_if.ws_allowin        = wsa;
      u_if.data_sram_data_ok = dok;
      u_if.data_sram_rdata   = rdata;
   endtask

   ins_t        m_ins;
   bit          m_v;
   logic [31:0] m_resp[$];

   initial begin
      vecs[0]  = '{"alu",      3'd0, 1'b0, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678};
      vecs[1]  = '{"ldb_a3",   3'd1, 1'b1, 1'b1, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80};
      vecs[2]  = '{"ldbu_a3",  3'd2, 1'b1, 1'b1, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080};
      vecs[3]  = '{"ldh_a2",   3'd3, 1'b1, 1'b1, 32'h0000_1002, 32'h8001_1234, 32'hFFFF_8001};
      vecs[4]  = '{"ldhu_a2",  3'd4, 1'b1, 1'b1, 32'h0000_1002, 32'h8001_1234, 32'h0000_8001};
      vecs[5]  = '{"ldh_a0",   3'd3, 1'b1, 1'b1, 32'h0000_1000, 32'h8001_1234, 32'h0000_1234};
      vecs[6]  = '{"ldh_a1",   3'd3, 1'b1, 1'b1, 32'h0000_1001, 32'h0000_F00D, 32'hFFFF_F00D};
      vecs[7]  = '{"ldb_a0",   3'd1, 1'b1, 1'b1, 32'h0000_1000, 32'h1234_567F, 32'h0000_007F};
      vecs[8]  = '{"ldb_a1",   3'd1, 1'b1, 1'b1, 32'h0000_1001, 32'h0000_8000, 32'hFFFF_FF80};
      vecs[9]  = '{"ldw",      3'd0, 1'b1, 1'b1, 32'h0000_1000, 32'hCAFE_BABE, 32'hCAFE_BABE};
      vecs[10] = '{"ld_type6", 3'd6, 1'b1, 1'b1, 32'h0000_1002, 32'h89AB_CDEF, 32'h89AB_CDEF};
      vecs[11] = '{"store",    3'd0, 1'b1, 1'b0, 32'h0000_A5A5, 32'h1111_1111, 32'h0000_A5A5};
      vecs[12] = '{"ldbu_a2",  3'd2, 1'b1, 1'b1, 32'h0000_1002, 32'h00AB_0000, 32'h0000_00AB};

      resetn = 1'b0;
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      tick(); tick();
      #3;
      chk("rst_allowin", u_if.ms_allowin, 1'b1);
      chk("rst_out_valid", u_if.ms_to_ws_valid, 1'b0);
      chk("rst_fwd_we", u_if.ms_fwd_bus[38], 1'b0);
      chk("rst_load_block", u_if.ms_fwd_bus[0], 1'b0);
      resetn = 1'b1;
      tick();

      for (int unsigned i = 0; i < 13; i++) begin
         drive(1'b1, pack(mk(vecs[i].ld, vecs[i].mreq, vecs[i].rfm, vecs[i].alu, 32'h1C00_0000 + 4 * i)),
               1'b1, 1'b0, '0);
         #3;
         chk({vecs[i].name, "_allowin"}, u_if.ms_allowin, 1'b1);
         tick();
         drive(1'b0, '0, 1'b1, vecs[i].mreq, vecs[i].rdata);
         #3;
         chk({vecs[i].name, "_valid"}, u_if.ms_to_ws_valid, 1'b1);
         chk({vecs[i].name, "_final"}, u_if.ms_to_ws_bus[63:32], vecs[i].exp);
         chk({vecs[i].name, "_dest"}, u_if.ms_to_ws_bus[68:64], 5'd5);
         chk({vecs[i].name, "_we"}, u_if.ms_to_ws_bus[69], 1'b1);
         chk({vecs[i].name, "_pc"}, u_if.ms_to_ws_bus[31:0], 32'h1C00_0000 + 4 * i);
         chk({vecs[i].name, "_fwd"}, u_if.ms_fwd_bus, {1'b1, 5'd5, vecs[i].exp, 1'b0});
         tick();
         drive(1'b0, '0, 1'b1, 1'b0, '0);
         #3;
         chk({vecs[i].name, "_drained"}, u_if.ms_to_ws_valid, 1'b0);
         tick();
      end

      // ld.h whose response arrives three cycles late
      drive(1'b1, pack(mk(3'd3, 1'b1, 1'b1, 32'h0000_2002, 32'h1C00_1000)), 1'b1, 1'b0, '0);
      #3; tick();
      for (int unsigned k = 0; k < 3; k++) begin
         drive(1'b0, '0, 1'b1, 1'b0, 32'h8001_1234);
         #3;
         chk("late_block", u_if.ms_fwd_bus[0], 1'b1);
         chk("late_valid", u_if.ms_to_ws_valid, 1'b0);
         chk("late_allowin", u_if.ms_allowin, 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b1, 1'b1, 32'h8001_1234);
      #3;
      chk("late_block_done", u_if.ms_fwd_bus[0], 1'b0);
      chk("late_valid_done", u_if.ms_to_ws_valid, 1'b1);
      chk("late_final", u_if.ms_to_ws_bus[63:32], 32'hFFFF_8001);
      chk("late_allowin_done", u_if.ms_allowin, 1'b1);
      tick();

      // ld.w response buffered while WB stalls; stray pulse while buffered is ignored
      drive(1'b1, pack(mk(3'd0, 1'b1, 1'b1, 32'h0000_3000, 32'h1C00_2000)), 1'b1, 1'b0, '0);
      #3; tick();
      drive(1'b0, '0, 1'b0, 1'b1, 32'hCAFE_BABE);
      #3;
      chk("buf_valid0", u_if.ms_to_ws_valid, 1'b1);
      chk("buf_allowin0", u_if.ms_allowin, 1'b0);
      chk("buf_final0", u_if.ms_to_ws_bus[63:32], 32'hCAFE_BABE);
      tick();
      drive(1'b0, '0, 1'b0, 1'b1, 32'h1111_1111);
      #3;
      chk("buf_final1", u_if.ms_to_ws_bus[63:32], 32'hCAFE_BABE);
      chk("buf_block1", u_if.ms_fwd_bus[0], 1'b0);
      tick();
      drive(1'b0, '0, 1'b1, 1'b0, 32'hDEAD_BEEF);
      #3;
      chk("buf_valid2", u_if.ms_to_ws_valid, 1'b1);
      chk("buf_final2", u_if.ms_to_ws_bus[63:32], 32'hCAFE_BABE);
      chk("buf_allowin2", u_if.ms_allowin, 1'b1);
      tick();
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      #3;
      chk("buf_drained", u_if.ms_to_ws_valid, 1'b0);
      tick();

      // back-to-back ld.w, one response per cycle (first pulse hits an empty stage)
      for (int unsigned k = 0; k < 6; k++) begin
         drive(k < 5, pack(mk(3'd0, 1'b1, 1'b1, 32'h0000_4000, 32'h1C00_3000 + 4 * k)),
               1'b1, 1'b1, 32'hA000_0000 + k);
         #3;
         chk("b2b_allowin", u_if.ms_allowin, 1'b1);
         if (k > 0) begin
            chk("b2b_valid", u_if.ms_to_ws_valid, 1'b1);
            chk("b2b_final", u_if.ms_to_ws_bus[63:32], 32'hA000_0000 + k);
            chk("b2b_pc", u_if.ms_to_ws_bus[31:0], 32'h1C00_3000 + 4 * (k - 1));
         end
         tick();
      end
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      #3;
      chk("b2b_drained", u_if.ms_to_ws_valid, 1'b0);
      tick();

      // reset while a load waits, then a late response
      drive(1'b1, pack(mk(3'd0, 1'b1, 1'b1, 32'h0000_5000, 32'h1C00_4000)), 1'b1, 1'b0, '0);
      #3; tick();
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      #3;
      chk("rstmid_block", u_if.ms_fwd_bus[0], 1'b1);
      tick();
      resetn = 1'b0;
      #3; tick();
      resetn = 1'b1;
      drive(1'b0, '0, 1'b1, 1'b1, 32'h1234_5678);
      #3;
      chk("rstmid_valid", u_if.ms_to_ws_valid, 1'b0);
      chk("rstmid_allowin", u_if.ms_allowin, 1'b1);
      chk("rstmid_fwd_we", u_if.ms_fwd_bus[38], 1'b0);
      chk("rstmid_block2", u_if.ms_fwd_bus[0], 1'b0);
      tick();
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      #3;
      chk("rstmid_valid2", u_if.ms_to_ws_valid, 1'b0);
      tick();

      // randomized traffic against the reference model
      resetn = 1'b0;
      @(posedge clk);
      m_v = 1'b0;
      m_resp.delete();
      #1;
      for (int unsigned c = 0; c < 3000; c++) begin
         ins_t        ni;
         logic        esv, wsa, dok, got, e_out, e_allow, e_block;
         logic [31:0] rd, e_data, e_final;
         ni.ld   = 3'($urandom_range(0, 7));
         ni.mreq = 1'($urandom_range(0, 1));
         ni.rfm  = ni.mreq & 1'($urandom_range(0, 1));
         ni.gwe  = 1'($urandom_range(0, 1));
         ni.dest = 5'($urandom);
         ni.alu  = $urandom;
         ni.pc   = $urandom;
         esv     = 1'($urandom_range(0, 1));
         wsa     = ($urandom_range(0, 3) != 0);
         dok     = 1'($urandom_range(0, 1));
         rd      = $urandom;
         resetn  = ($urandom_range(0, 99) >= 2);
         drive(esv, pack(ni), wsa, dok, rd);
         #3;
         got     = dok || (m_resp.size() != 0);
         e_out   = m_v && (!m_ins.mreq || got);
         e_allow = !m_v || (e_out && wsa);
         e_block = m_v && m_ins.rfm && !got;
         e_data  = (m_resp.size() != 0) ? m_resp[0] : rd;
         e_final = m_ins.rfm ? extract(m_ins.ld, m_ins.alu[1:0], e_data) : m_ins.alu;
         chk("rnd_allowin", u_if.ms_allowin, e_allow);
         chk("rnd_valid", u_if.ms_to_ws_valid, e_out);
         chk("rnd_block", u_if.ms_fwd_bus[0], e_block);
         chk("rnd_fwd_we", u_if.ms_fwd_bus[38], m_v && m_ins.gwe);
         if (m_v) begin
            chk("rnd_passthru", u_if.ms_to_ws_bus[69:64], {m_ins.gwe, m_ins.dest});
            chk("rnd_pc", u_if.ms_to_ws_bus[31:0], m_ins.pc);
            chk("rnd_fwd_dest", u_if.ms_fwd_bus[37:33], m_ins.dest);
         end
         if (e_out) begin
            chk("rnd_final", u_if.ms_to_ws_bus[63:32], e_final);
            chk("rnd_fwd_final", u_if.ms_fwd_bus[32:1], e_final);
         end
         @(posedge clk);
         if (!resetn) begin
            m_v = 1'b0;
            m_resp.delete();
         end else if (e_allow) begin
            m_v = esv;
            if (esv) begin
               m_ins = ni;
               m_resp.delete();
            end
         end else if (m_v && m_ins.mreq && dok && m_resp.size() == 0) begin
            m_resp.push_back(rd);
         end
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ES_TO_MS_BUS_WD, default 75, width of the EX-to-MEM bus.
REQ-002 SHALL have parameter MS_TO_WS_BUS_WD, default 70, width of the MEM-to-WB bus.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset; synchronous, active-low.
REQ-005 ms_allowin  output  1  MEM can accept an instruction this cycle.
REQ-006 es_to_ms_valid  input  1  EX presents a valid instruction.
REQ-007 es_to_ms_bus  input  75  {ld_type[74:72], mem_req[71], res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
REQ-008 ws_allowin  input  1  WB can accept.
REQ-009 ms_to_ws_valid  output  1  MEM presents a completed instruction to WB.
REQ-010 ms_to_ws_bus  output  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-011 data_sram_data_ok  input  1  one-cycle pulse: response for the access issued by EX for the instruction now in MEM.
REQ-012 data_sram_rdata  input  32  read data; valid only when data_sram_data_ok=1.
REQ-013 ms_fwd_bus  output  39  {ms_valid&&gr_we[38], dest[37:33], final_result[32:1], ms_load_block[0]} for ID bypass.

Function
REQ-014 SHALL hold internal ms_valid, a latched bus register, resp_buf_valid and resp_buf[31:0].
REQ-015 Accept = es_to_ms_valid && ms_allowin; on accept, bus register SHALL load es_to_ms_bus and resp_buf_valid SHALL clear, same edge.
REQ-016 ms_valid next = es_to_ms_valid when ms_allowin=1, else hold.
REQ-017 resp_got = data_sram_data_ok || resp_buf_valid; ms_ready_go = !mem_req || resp_got.
REQ-018 ms_allowin = !ms_valid || (ms_ready_go && ws_allowin); ms_to_ws_valid = ms_valid && ms_ready_go (combinational).
REQ-019 data_sram_data_ok while ms_valid && mem_req && !resp_buf_valid && !ws_allowin SHALL capture rdata into resp_buf and set resp_buf_valid.
REQ-020 data_sram_data_ok while !ms_valid, !mem_req or resp_buf_valid=1 SHALL be ignored (no state change).
REQ-021 mem_rdata = resp_buf_valid ? resp_buf : data_sram_rdata.
REQ-022 Load extract by a = alu_result[1:0]: ld_type 000 ld.w word; 001 ld.b sign-ext byte a; 010 ld.bu zero-ext byte a; 011 ld.h sign-ext half a[1]; 100 ld.hu zero-ext half a[1]; 101-111 treated as ld.w.
REQ-023 Alignment NOT checked here (EX raises ALE); a[0] ignored for halfwords.
REQ-024 final_result = res_from_mem ? extracted load data : alu_result.
REQ-025 Stores (mem_req=1, res_from_mem=0) SHALL also stall until resp_got; final_result = alu_result.
REQ-026 ms_load_block = ms_valid && res_from_mem && !resp_got.
REQ-027 ms_to_ws_bus pc, dest, gr_we SHALL pass through unchanged from the latched bus.
REQ-028 Latency: non-memory op 1 cycle in MEM; memory op leaves in the cycle resp_got=1 and ws_allowin=1.
REQ-029 Simultaneous leave and accept: old instruction consumes this-cycle data_ok directly; new bus latched, buffer cleared.

Reset
REQ-030 resetn=0 at a clock edge SHALL clear ms_valid and resp_buf_valid; bus register and resp_buf undefined.
REQ-031 During/after reset: ms_allowin=1, ms_to_ws_valid=0, ms_fwd_bus[38]=0, ms_load_block=0.
REQ-032 Reset mid-access SHALL drop the instruction; a data_ok arriving after reset is ignored per REQ-020.

Verification
REQ-033 ALU op, alu_result=0x12345678, gr_we=1, dest=5, ws_allowin=1 -> next cycle ms_to_ws_valid=1, bus final_result=0x12345678, dest=5.
REQ-034 ld.b, addr low=2'b11, data_ok same cycle, rdata=0x80FF_0000 -> final_result=0xFFFFFF80; ld.bu -> 0x00000080.
REQ-035 ld.h, addr=..10, rdata=0x8001_1234, data_ok 3 cycles late -> ms_load_block=1 for 3 cycles, then final_result=0xFFFF8001.
REQ-036 ld.w, data_ok=1 with ws_allowin=0 for 2 cycles, rdata changes after pulse -> buffered 0xCAFEBABE delivered when ws_allowin=1.
REQ-037 Back-to-back ld.w with data_ok every cycle, ws_allowin=1 -> one instruction per cycle, ms_allowin constantly 1.
REQ-038 resetn=0 while load waits, then data_ok pulse -> ms_to_ws_valid stays 0, ms_allowin=1.
